// File: rtl/memory_latency_sim_queue_if.sv
// Request/release bus of the memory latency queue.
// master: the arbiter side plus the memory-side ready; slave: the queue itself.
interface memory_latency_sim_queue_if #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned SERIAL_WIDTH = 8,
    parameter int unsigned COUNT_WIDTH  = 8
);
    logic                    reqValid;
    logic                    reqReady;
    logic                    reqIsRead;
    logic                    reqIsWrite;
    logic [ADDR_WIDTH-1:0]   reqAddr;
    logic [DATA_WIDTH-1:0]   reqWriteData;
    logic [SERIAL_WIDTH-1:0] reqReadSerial;
    logic [SERIAL_WIDTH-1:0] reqWriteSerial;

    logic                    outValid;
    logic                    outReady;
    logic                    outIsRead;
    logic                    outIsWrite;
    logic [ADDR_WIDTH-1:0]   outAddr;
    logic [DATA_WIDTH-1:0]   outWriteData;
    logic [SERIAL_WIDTH-1:0] outReadSerial;
    logic [SERIAL_WIDTH-1:0] outWriteSerial;

    logic [COUNT_WIDTH-1:0]  count;

    modport master (
        output reqValid, reqIsRead, reqIsWrite, reqAddr, reqWriteData, reqReadSerial,
               reqWriteSerial, outReady,
        input  reqReady, outValid, outIsRead, outIsWrite, outAddr, outWriteData, outReadSerial,
               outWriteSerial, count
    );

    modport slave (
        input  reqValid, reqIsRead, reqIsWrite, reqAddr, reqWriteData, reqReadSerial,
               reqWriteSerial, outReady,
        output reqReady, outValid, outIsRead, outIsWrite, outAddr, outWriteData, outReadSerial,
               outWriteSerial, count
    );
endinterface

// File: rtl/memory_latency_sim_queue.sv
// In-order delay queue in front of the memory model. Each accepted request is tagged with a
// pseudo-random extra latency (xorshift32) and only released once it has sat at the head that long.
module memory_latency_sim_queue #(
    parameter int unsigned QUEUE_SIZE        = 128,
    parameter int unsigned FLUCTUATION_RANGE = 10,
    parameter logic [31:0] RAND_SEED         = 32'd1987534242,
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned SERIAL_WIDTH      = 8
) (
    input logic clk,
    input logic rst,
    memory_latency_sim_queue_if.slave bus
);
    localparam int unsigned PTR_WIDTH   = $clog2(QUEUE_SIZE);
    localparam int unsigned COUNT_WIDTH = PTR_WIDTH + 1;
    localparam int unsigned LAT_WIDTH   = $clog2(FLUCTUATION_RANGE + 1);

    typedef struct packed {
        logic                    is_read;
        logic                    is_write;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   data;
        logic [SERIAL_WIDTH-1:0] read_serial;
        logic [SERIAL_WIDTH-1:0] write_serial;
    } payload_t;

    typedef struct packed {
        payload_t             payload;
        logic [LAT_WIDTH-1:0] lat;
    } entry_t;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    entry_t               mem [QUEUE_SIZE];
    logic [PTR_WIDTH-1:0] head_ptr_q, tail_ptr_q;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [31:0]          rand_q, rand_d;
    logic [LAT_WIDTH-1:0] head_wait_q, head_wait_d;
    logic                 head_loaded_q, head_loaded_d;
    payload_t             head_q, head_d;
    entry_t               req_entry, next_entry;
    logic                 push, pop, out_valid;

    // Ready depends on registered occupancy only, so a full queue refuses even while popping.
    assign bus.reqReady = (count_q != COUNT_WIDTH'(QUEUE_SIZE));
    assign out_valid    = (count_q != '0) && (head_wait_q == '0) && head_loaded_q;
    assign push         = bus.reqValid && bus.reqReady;
    assign pop          = out_valid && bus.outReady;
    assign next_entry   = mem[head_ptr_q + 1'b1];

    assign bus.outValid       = out_valid;
    assign bus.outIsRead      = head_q.is_read;
    assign bus.outIsWrite     = head_q.is_write;
    assign bus.outAddr        = head_q.addr;
    assign bus.outWriteData   = head_q.data;
    assign bus.outReadSerial  = head_q.read_serial;
    assign bus.outWriteSerial = head_q.write_serial;
    assign bus.count          = count_q;

    // Pack the incoming request with its latency drawn from the pre-advance random state.
    always_comb begin
        req_entry = '0;
        req_entry.payload.is_read      = bus.reqIsRead;
        req_entry.payload.is_write     = bus.reqIsWrite;
        req_entry.payload.addr         = bus.reqAddr;
        req_entry.payload.data         = bus.reqWriteData;
        req_entry.payload.read_serial  = bus.reqReadSerial;
        req_entry.payload.write_serial = bus.reqWriteSerial;
        req_entry.lat                  = LAT_WIDTH'(rand_q % FLUCTUATION_RANGE);
    end

    // Next occupancy, random state and head register contents.
    always_comb begin
        count_d       = count_q;
        rand_d        = rand_q;
        head_d        = head_q;
        head_loaded_d = head_loaded_q;
        head_wait_d   = (head_wait_q != '0) ? head_wait_q - 1'b1 : head_wait_q;

        if (push) begin
            rand_d = xorshift32(rand_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (pop) begin
            if (count_q > COUNT_WIDTH'(1)) begin
                head_d        = next_entry.payload;
                head_wait_d   = next_entry.lat;
                head_loaded_d = 1'b1;
            end else if (push) begin
                // Only entry leaves while a new one arrives: the arrival becomes head.
                head_d        = req_entry.payload;
                head_wait_d   = req_entry.lat;
                head_loaded_d = 1'b1;
            end else begin
                head_d        = '0;
                head_wait_d   = '0;
                head_loaded_d = 1'b0;
            end
        end else if (push && (count_q == '0)) begin
            head_d        = req_entry.payload;
            head_wait_d   = req_entry.lat;
            head_loaded_d = 1'b1;
        end
    end

    // Control state; async reset drops every queued entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr_q    <= '0;
            tail_ptr_q    <= '0;
            count_q       <= '0;
            rand_q        <= RAND_SEED;
            head_wait_q   <= '0;
            head_loaded_q <= 1'b0;
            head_q        <= '0;
        end else begin
            if (push) tail_ptr_q <= tail_ptr_q + 1'b1;
            if (pop)  head_ptr_q <= head_ptr_q + 1'b1;
            count_q       <= count_d;
            rand_q        <= rand_d;
            head_wait_q   <= head_wait_d;
            head_loaded_q <= head_loaded_d;
            head_q        <= head_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr_q] <= req_entry;
    end

    a_no_read_and_write: assert property (
        @(posedge clk) disable iff (rst) !(push && bus.reqIsRead && bus.reqIsWrite));
endmodule

// File: tb/tb_memory_latency_sim_queue.sv
// Directed bench: a 4-deep zero-jitter instance driven from a cycle table, plus the default
// instance exercised with hand-written latency, back-pressure, full and reset sequences.
module tb_memory_latency_sim_queue;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    memory_latency_sim_queue_if #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .SERIAL_WIDTH(8), .COUNT_WIDTH(3)
    ) bus_a ();
    memory_latency_sim_queue_if #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .SERIAL_WIDTH(8), .COUNT_WIDTH(8)
    ) bus_b ();

    memory_latency_sim_queue #(
        .QUEUE_SIZE(4), .FLUCTUATION_RANGE(1)
    ) u_small (
        .clk(clk), .rst(rst_a), .bus(bus_a)
    );

    memory_latency_sim_queue u_dut (
        .clk(clk), .rst(rst_b), .bus(bus_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    typedef struct {
        logic        v;
        logic        rd;
        logic [31:0] addr;
        logic        ordy;
        logic        e_v;
        logic [31:0] e_addr;
        logic [2:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [31:0] x;
        int          lat [4];
        int          exp_cyc [4];
        int          got_cyc [4];
        logic [31:0] got_addr [4];
        int          n_seen;
        int          k;
        int          first;

        // Inputs sampled at the end of the row; expectations hold during the row.
        tbl[0]  = '{0, 0, 32'h000, 1,  0, 32'h000, 0, 1};
        tbl[1]  = '{1, 1, 32'h100, 1,  0, 32'h000, 0, 1};
        tbl[2]  = '{0, 0, 32'h000, 1,  1, 32'h100, 1, 1};
        tbl[3]  = '{0, 0, 32'h000, 1,  0, 32'h000, 0, 1};
        tbl[4]  = '{1, 0, 32'h200, 0,  0, 32'h000, 0, 1};
        tbl[5]  = '{1, 0, 32'h204, 0,  1, 32'h200, 1, 1};
        tbl[6]  = '{1, 0, 32'h208, 0,  1, 32'h200, 2, 1};
        tbl[7]  = '{1, 0, 32'h20c, 0,  1, 32'h200, 3, 1};
        tbl[8]  = '{1, 0, 32'h210, 0,  1, 32'h200, 4, 0};
        tbl[9]  = '{1, 0, 32'h214, 1,  1, 32'h200, 4, 0};
        tbl[10] = '{0, 0, 32'h000, 1,  1, 32'h204, 3, 1};
        tbl[11] = '{1, 0, 32'h218, 1,  1, 32'h208, 2, 1};
        tbl[12] = '{0, 0, 32'h000, 1,  1, 32'h20c, 2, 1};
        tbl[13] = '{0, 0, 32'h000, 1,  1, 32'h218, 1, 1};
        tbl[14] = '{1, 1, 32'h300, 1,  0, 32'h000, 0, 1};
        tbl[15] = '{1, 1, 32'h304, 1,  1, 32'h300, 1, 1};
        tbl[16] = '{0, 0, 32'h000, 1,  1, 32'h304, 1, 1};
        tbl[17] = '{0, 0, 32'h000, 1,  0, 32'h000, 0, 1};

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.reqValid = 0; bus_a.reqIsRead = 0; bus_a.reqIsWrite = 0; bus_a.reqAddr = '0;
        bus_a.reqWriteData = '0; bus_a.reqReadSerial = '0; bus_a.reqWriteSerial = '0;
        bus_a.outReady = 0;
        bus_b.reqValid = 0; bus_b.reqIsRead = 0; bus_b.reqIsWrite = 0; bus_b.reqAddr = '0;
        bus_b.reqWriteData = '0; bus_b.reqReadSerial = '0; bus_b.reqWriteSerial = '0;
        bus_b.outReady = 0;
        repeat (2) @(negedge clk);
        check("b.reset.valid", bus_b.outValid, 0);
        check("b.reset.ready", bus_b.reqReady, 1);
        check("b.reset.count", bus_b.count, 0);
        check("b.reset.addr", bus_b.outAddr, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Zero-jitter instance, cycle table.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check($sformatf("small[%0d].valid", i), bus_a.outValid, tbl[i].e_v);
            check($sformatf("small[%0d].addr", i), bus_a.outAddr, tbl[i].e_addr);
            check($sformatf("small[%0d].count", i), bus_a.count, tbl[i].e_cnt);
            check($sformatf("small[%0d].ready", i), bus_a.reqReady, tbl[i].e_rdy);
            bus_a.reqValid   = tbl[i].v;
            bus_a.reqIsRead  = tbl[i].v && tbl[i].rd;
            bus_a.reqIsWrite = tbl[i].v && !tbl[i].rd;
            bus_a.reqAddr    = tbl[i].addr;
            bus_a.outReady   = tbl[i].ordy;
        end

        // Release order and per-entry latency against the xorshift reference.
        x = 32'd1987534242;
        for (int j = 0; j < 4; j++) begin
            lat[j] = int'(x % 32'd10);
            x = xs(x);
            got_cyc[j]  = -1;
            got_addr[j] = 32'hdead_beef;
        end
        exp_cyc[0] = 1 + lat[0];
        for (int j = 1; j < 4; j++) exp_cyc[j] = exp_cyc[j-1] + 1 + lat[j];
        bus_b.outReady = 1;
        n_seen = 0;
        for (int i = 0; i < 200 && n_seen < 4; i++) begin
            @(negedge clk);
            if (bus_b.outValid) begin
                got_cyc[n_seen]  = i;
                got_addr[n_seen] = bus_b.outAddr;
                n_seen++;
            end
            bus_b.reqValid   = (i < 4);
            bus_b.reqIsRead  = (i < 4);
            bus_b.reqIsWrite = 0;
            bus_b.reqAddr    = 32'(i * 8);
        end
        bus_b.reqValid = 0;
        bus_b.reqIsRead = 0;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("lat.addr[%0d]", j), got_addr[j], 32'(j * 8));
            check($sformatf("lat.cycle[%0d]", j), got_cyc[j], exp_cyc[j]);
        end
        @(negedge clk);
        check("lat.count_after", bus_b.count, 0);

        // Held output under back-pressure.
        bus_b.outReady       = 0;
        bus_b.reqValid       = 1;
        bus_b.reqIsWrite     = 1;
        bus_b.reqAddr        = 32'h400;
        bus_b.reqWriteData   = 64'h1122_3344_5566_7788;
        bus_b.reqWriteSerial = 8'h5a;
        @(negedge clk);
        bus_b.reqValid = 0;
        for (int i = 0; i < 20 && !bus_b.outValid; i++) @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            if (j != 0) @(negedge clk);
            check($sformatf("hold[%0d].valid", j), bus_b.outValid, 1);
            check($sformatf("hold[%0d].addr_ser", j), {bus_b.outAddr, bus_b.outWriteSerial},
                  {32'h400, 8'h5a});
            check($sformatf("hold[%0d].data", j), bus_b.outWriteData, 64'h1122_3344_5566_7788);
        end
        @(negedge clk);
        check("hold.valid6", bus_b.outValid, 1);
        bus_b.outReady = 1;
        @(negedge clk);
        check("hold.popped_count", bus_b.count, 0);
        check("hold.popped_valid", bus_b.outValid, 0);
        check("hold.empty_data", bus_b.outWriteData, 0);
        bus_b.outReady = 0;

        // Fill to capacity, refuse overflow, simultaneous push+pop while full, then drain.
        for (int i = 0; i < 128; i++) begin
            bus_b.reqValid       = 1;
            bus_b.reqIsWrite     = 1;
            bus_b.reqAddr        = 32'(i * 8);
            bus_b.reqWriteData   = {32'h0bad_0000 + 32'(i), 32'h1357_0000 + 32'(i)};
            bus_b.reqReadSerial  = 8'(255 - i);
            bus_b.reqWriteSerial = 8'(i);
            @(negedge clk);
        end
        check("full.count", bus_b.count, 128);
        check("full.ready", bus_b.reqReady, 0);
        bus_b.reqAddr      = 32'hfff8;
        bus_b.reqWriteData = 64'hffff_ffff_ffff_ffff;
        @(negedge clk);
        check("full.refused_count", bus_b.count, 128);
        check("full.head_valid", bus_b.outValid, 1);
        check("full.head_addr", bus_b.outAddr, 0);
        check("full.head_data", bus_b.outWriteData, {32'h0bad_0000, 32'h1357_0000});
        bus_b.outReady = 1;
        @(negedge clk);
        check("full.pushpop_count", bus_b.count, 127);
        bus_b.reqValid = 0;
        k = 1;
        for (int i = 0; i < 2000 && k < 128; i++) begin
            if (bus_b.outValid) begin
                check($sformatf("drain[%0d].addr_ser", k),
                      {bus_b.outAddr, bus_b.outWriteSerial, bus_b.outReadSerial},
                      {32'(k * 8), 8'(k), 8'(255 - k)});
                check($sformatf("drain[%0d].data", k), bus_b.outWriteData,
                      {32'h0bad_0000 + 32'(k), 32'h1357_0000 + 32'(k)});
                k++;
            end
            @(negedge clk);
        end
        check("drain.done", k, 128);
        check("drain.count", bus_b.count, 0);

        // Reset mid-delay, then confirm the random state restarted from the seed.
        bus_b.outReady = 0;
        bus_b.reqValid = 1;
        for (int i = 0; i < 3; i++) begin
            bus_b.reqAddr = 32'h600 + 32'(i);
            @(negedge clk);
        end
        bus_b.reqValid = 0;
        #2 rst_b = 1'b1;
        #1;
        check("rst.valid", bus_b.outValid, 0);
        check("rst.count", bus_b.count, 0);
        check("rst.ready", bus_b.reqReady, 1);
        @(negedge clk);
        rst_b = 1'b0;
        bus_b.outReady = 1;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_b.outValid && first < 0) begin
                first = i;
                check("rst.first_addr", bus_b.outAddr, 32'h700);
            end
            bus_b.reqValid   = (i == 0);
            bus_b.reqIsRead  = (i == 0);
            bus_b.reqIsWrite = 0;
            bus_b.reqAddr    = 32'h700;
        end
        check("rst.first_cycle", first, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
